// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit add/sub unit and the blocks around it.
// Holds the FuncCode encodings and the default operand width. The add/sub unit
// and alu_cmd_queue both import this package so they agree on the encodings.
package alu_pkg;

   // Default operand/result width of the add/sub datapath.
   localparam int unsigned DATA_WIDTH = 16;

   // FuncCode width and encodings. Codes other than these give a zero result.
   localparam int unsigned FUNC_WIDTH = 4;
   localparam logic [FUNC_WIDTH-1:0] FUNC_ADD = 4'b0000;
   localparam logic [FUNC_WIDTH-1:0] FUNC_SUB = 4'b0001;

endpackage : alu_pkg

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for alu_cmd_queue.
// Stores {a, b, func} commands in a power-of-two ring buffer. It also drives the
// head entry to the add/sub unit and reports occupancy.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   in_valid_i      command offered
//   in_ready_o      room available (count < depth); depends on registered count only
//   in_a_i, in_b_i  operands of the offered command
//   in_func_i       FuncCode of the offered command
//   pop_i           head entry consumed this edge (ignored while empty)
//   head_a_o/b_o    head operands, zero while empty
//   head_func_o     head FuncCode, FUNC_ADD (all zero) while empty
//   count_o         number of stored commands
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int unsigned data_width = DATA_WIDTH,
   parameter int unsigned depth      = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           in_valid_i,
   output logic                           in_ready_o,
   input  logic [data_width-1:0]          in_a_i,
   input  logic [data_width-1:0]          in_b_i,
   input  logic [FUNC_WIDTH-1:0]          in_func_i,
   input  logic                           pop_i,
   output logic [data_width-1:0]          head_a_o,
   output logic [data_width-1:0]          head_b_o,
   output logic [FUNC_WIDTH-1:0]          head_func_o,
   output logic [$clog2(depth+1)-1:0]     count_o
);

   localparam int unsigned PtrW = $clog2(depth);
   localparam int unsigned CntW = $clog2(depth + 1);

   logic [data_width-1:0] mem_a_q    [depth];
   logic [data_width-1:0] mem_a_d    [depth];
   logic [data_width-1:0] mem_b_q    [depth];
   logic [data_width-1:0] mem_b_d    [depth];
   logic [FUNC_WIDTH-1:0] mem_func_q [depth];
   logic [FUNC_WIDTH-1:0] mem_func_d [depth];

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;

   logic empty;
   logic push;
   logic pop;

   assign empty      = (count_q == '0);
   assign in_ready_o = (count_q < CntW'(depth));
   // No bypass: a full queue refuses even when a pop frees a slot on the same edge.
   assign push       = in_valid_i & in_ready_o;
   assign pop        = pop_i & ~empty;

   always_comb begin
      mem_a_d    = mem_a_q;
      mem_b_d    = mem_b_q;
      mem_func_d = mem_func_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;

      if (push) begin
         mem_a_d[wr_ptr_q]    = in_a_i;
         mem_b_d[wr_ptr_q]    = in_b_i;
         mem_func_d[wr_ptr_q] = in_func_i;
         // depth is a power of two, so the natural pointer rollover is modulo depth.
         wr_ptr_d             = wr_ptr_q + PtrW'(1);
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(depth); i++) begin
            mem_a_q[i]    <= '0;
            mem_b_q[i]    <= '0;
            mem_func_q[i] <= FUNC_ADD;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_a_q    <= mem_a_d;
         mem_b_q    <= mem_b_d;
         mem_func_q <= mem_func_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Head is forced to zero while empty so the add/sub unit sees a benign 0 + 0.
   always_comb begin
      head_a_o    = '0;
      head_b_o    = '0;
      head_func_o = FUNC_ADD;
      if (!empty) begin
         head_a_o    = mem_a_q[rd_ptr_q];
         head_b_o    = mem_b_q[rd_ptr_q];
         head_func_o = mem_func_q[rd_ptr_q];
      end
   end

   assign count_o = count_q;

endmodule : alu_cmd_fifo

// File: rtl/alu_cmd_queue.sv
// Command buffer and result-capture stage around the external 16-bit add/sub unit.
// Commands arrive over a valid/ready handshake into alu_cmd_fifo. The head command
// drives the add/sub unit. Its result is registered into a single output slot and
// handed downstream over a second valid/ready handshake. A sticky overflow flag
// records any captured overflow until cleared.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   in_valid/in_ready    command handshake; in_ready = (count < depth)
//   in_a, in_b, in_func  command operands and FuncCode
//   alu_a, alu_b         head operands to the add/sub unit (zero when empty)
//   alu_func             head FuncCode to the add/sub unit (0000 when empty)
//   alu_c, alu_ovf       add/sub unit result and overflow flag
//   out_valid/out_ready  result handshake
//   out_c, out_ovf       registered result and its overflow flag
//   sticky_ovf           set by any captured overflow
//   clear_sticky         synchronous clear of sticky_ovf (a same-edge set wins)
//   count                FIFO occupancy
module alu_cmd_queue
   import alu_pkg::*;
#(
   parameter int unsigned data_width = DATA_WIDTH,
   parameter int unsigned depth      = 4
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [data_width-1:0]       in_a,
   input  logic [data_width-1:0]       in_b,
   input  logic [3:0]                  in_func,
   output logic [data_width-1:0]       alu_a,
   output logic [data_width-1:0]       alu_b,
   output logic [3:0]                  alu_func,
   input  logic [data_width-1:0]       alu_c,
   input  logic                        alu_ovf,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [data_width-1:0]       out_c,
   output logic                        out_ovf,
   output logic                        sticky_ovf,
   input  logic                        clear_sticky,
   output logic [$clog2(depth+1)-1:0]  count
);

   logic                  out_valid_q, out_valid_d;
   logic [data_width-1:0] out_c_q, out_c_d;
   logic                  out_ovf_q, out_ovf_d;
   logic                  sticky_ovf_q, sticky_ovf_d;

   logic capture;

   alu_cmd_fifo #(
      .data_width (data_width),
      .depth      (depth)
   ) u_fifo (
      .clk_i       (clk),
      .rst_ni      (reset_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_a_i      (in_a),
      .in_b_i      (in_b),
      .in_func_i   (in_func),
      .pop_i       (capture),
      .head_a_o    (alu_a),
      .head_b_o    (alu_b),
      .head_func_o (alu_func),
      .count_o     (count)
   );

   // The slot takes a new result when it is empty or being drained this edge.
   assign capture = (count != '0) & (~out_valid_q | out_ready);

   always_comb begin
      out_valid_d  = out_valid_q;
      out_c_d      = out_c_q;
      out_ovf_d    = out_ovf_q;
      sticky_ovf_d = sticky_ovf_q;

      if (capture) begin
         out_valid_d = 1'b1;
         out_c_d     = alu_c;
         out_ovf_d   = alu_ovf;
      end else if (out_ready) begin
         // Drain only; the data fields keep their last values.
         out_valid_d = 1'b0;
      end

      if (clear_sticky) begin
         sticky_ovf_d = 1'b0;
      end
      // Evaluated after the clear so a coincident overflow capture wins.
      if (capture && alu_ovf) begin
         sticky_ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q  <= 1'b0;
         out_c_q      <= '0;
         out_ovf_q    <= 1'b0;
         sticky_ovf_q <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_c_q      <= out_c_d;
         out_ovf_q    <= out_ovf_d;
         sticky_ovf_q <= sticky_ovf_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_c      = out_c_q;
   assign out_ovf    = out_ovf_q;
   assign sticky_ovf = sticky_ovf_q;

endmodule : alu_cmd_queue

// File: tb/tb_alu_cmd_queue.sv
// Self-checking bench for alu_cmd_queue with a behavioural add/sub unit attached.
module tb_alu_cmd_queue;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a, in_b;
   logic [3:0]  in_func;
   logic [15:0] alu_a, alu_b;
   logic [3:0]  alu_func;
   logic [15:0] alu_c;
   logic        alu_ovf;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_c;
   logic        out_ovf;
   logic        sticky_ovf;
   logic        clear_sticky;
   logic [2:0]  count;

   int checks = 0;
   int failures = 0;
   logic [16:0] sb_q[$];

   always #5 clk = ~clk;

   alu_cmd_queue #(
      .data_width (16),
      .depth      (4)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_func      (in_func),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_func     (alu_func),
      .alu_c        (alu_c),
      .alu_ovf      (alu_ovf),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_c        (out_c),
      .out_ovf      (out_ovf),
      .sticky_ovf   (sticky_ovf),
      .clear_sticky (clear_sticky),
      .count        (count)
   );

   // Reference add/sub behaviour: {overflow, result}.
   function automatic logic [16:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] f);
      logic [15:0] c;
      logic        v;
      c = '0;
      v = 1'b0;
      if (f == FUNC_ADD) begin
         c = a + b;
         v = (a[15] == b[15]) && (c[15] != a[15]);
      end else if (f == FUNC_SUB) begin
         c = a - b;
         v = (a[15] != b[15]) && (c[15] != a[15]);
      end
      return {v, c};
   endfunction

   assign {alu_ovf, alu_c} = ref_alu(alu_a, alu_b, alu_func);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard bookkeeping for the edge about to happen, then advance one cycle.
   task automatic step();
      if (in_valid && in_ready) sb_q.push_back(ref_alu(in_a, in_b, in_func));
      if (out_valid && out_ready) begin
         if (sb_q.size() == 0) check("unexpected_out", 32'(out_valid), 32'd0);
         else check("sb_result", {15'd0, out_ovf, out_c}, {15'd0, sb_q.pop_front()});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_func  = f;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 20 && (sb_q.size() != 0 || out_valid); i++) step();
      check(tag, 32'(sb_q.size()), 32'd0);
      check({tag, "_count"}, 32'(count), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      in_func = '0;
      out_ready = 1'b0;
      clear_sticky = 1'b0;
      #1;
      check("rst_count", 32'(count), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_c", 32'(out_c), 32'd0);
      check("rst_sticky", 32'(sticky_ovf), 32'd0);
      check("rst_alu_func", 32'(alu_func), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Single add: result valid two edges after the push.
      out_ready = 1'b1;
      set_cmd(16'h0003, 16'h0004, FUNC_ADD);
      step();
      idle();
      check("t1_count1", 32'(count), 32'd1);
      check("t1_head_a", 32'(alu_a), 32'h3);
      check("t1_not_yet", 32'(out_valid), 32'd0);
      step();
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_c", 32'(out_c), 32'h7);
      check("t1_ovf", 32'(out_ovf), 32'd0);
      check("t1_count0", 32'(count), 32'd0);
      step();
      check("t1_drained", 32'(out_valid), 32'd0);

      // Overflow and sticky flag.
      set_cmd(16'h7FFF, 16'h0001, FUNC_ADD);
      step();
      set_cmd(16'h8000, 16'h0001, FUNC_SUB);
      step();
      idle();
      check("t2_c_add", 32'(out_c), 32'h8000);
      check("t2_ovf_add", 32'(out_ovf), 32'd1);
      check("t2_sticky", 32'(sticky_ovf), 32'd1);
      step();
      check("t2_c_sub", 32'(out_c), 32'h7FFF);
      check("t2_ovf_sub", 32'(out_ovf), 32'd1);
      step();
      step();
      check("t2_sticky_hold", 32'(sticky_ovf), 32'd1);
      clear_sticky = 1'b1;
      step();
      clear_sticky = 1'b0;
      check("t2_sticky_clr", 32'(sticky_ovf), 32'd0);
      set_cmd(16'h7FFF, 16'h0001, FUNC_ADD);
      step();
      idle();
      clear_sticky = 1'b1;
      step();
      clear_sticky = 1'b0;
      check("t2_set_wins", 32'(sticky_ovf), 32'd1);
      step();
      clear_sticky = 1'b1;
      step();
      clear_sticky = 1'b0;
      check("t2_sticky_clr2", 32'(sticky_ovf), 32'd0);

      // Fill and backpressure: 4 queued + 1 in the slot, the next offer refused.
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         set_cmd(16'h0010 + 16'(i), 16'h0001, FUNC_ADD);
         check("t3_in_ready", 32'(in_ready), (i < 5) ? 32'd1 : 32'd0);
         step();
      end
      idle();
      check("t3_count_full", 32'(count), 32'd4);
      check("t3_ready_low", 32'(in_ready), 32'd0);
      check("t3_held_valid", 32'(out_valid), 32'd1);
      check("t3_held_c", 32'(out_c), 32'h11);
      step();
      step();
      check("t3_stable_c", 32'(out_c), 32'h11);
      check("t3_stable_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("t3_b2b_valid", 32'(out_valid), 32'd1);
         step();
      end
      check("t3_empty_valid", 32'(out_valid), 32'd0);
      check("t3_empty_count", 32'(count), 32'd0);
      check("t3_sb_empty", 32'(sb_q.size()), 32'd0);

      // Steady push+capture at count 2; pointers wrap over 12 commands.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_cmd(16'($urandom), 16'($urandom), 4'($urandom_range(0, 1)));
         step();
      end
      check("t4_count_start", 32'(count), 32'd2);
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         set_cmd(16'($urandom), 16'($urandom), 4'($urandom_range(0, 1)));
         step();
         check("t4_count_hold", 32'(count), 32'd2);
      end
      idle();
      drain("t4_drain");

      // Undefined FuncCode yields zero without disturbing order.
      set_cmd(16'h0001, 16'h0001, FUNC_ADD);
      step();
      set_cmd(16'h1234, 16'h1111, 4'b0101);
      step();
      set_cmd(16'h0005, 16'h0003, FUNC_SUB);
      step();
      idle();
      check("t5_undef_valid", 32'(out_valid), 32'd1);
      check("t5_undef_c", 32'(out_c), 32'h0);
      check("t5_undef_ovf", 32'(out_ovf), 32'd0);
      drain("t5_drain");

      // Asynchronous reset with commands queued and a result pending.
      out_ready = 1'b0;
      set_cmd(16'h7FFF, 16'h0001, FUNC_ADD);
      step();
      set_cmd(16'h0002, 16'h0002, FUNC_ADD);
      step();
      set_cmd(16'h0003, 16'h0003, FUNC_ADD);
      step();
      set_cmd(16'h0004, 16'h0004, FUNC_ADD);
      step();
      idle();
      check("t6_count3", 32'(count), 32'd3);
      check("t6_valid", 32'(out_valid), 32'd1);
      check("t6_c", 32'(out_c), 32'h8000);
      check("t6_sticky", 32'(sticky_ovf), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_rst_count", 32'(count), 32'd0);
      check("t6_rst_ready", 32'(in_ready), 32'd1);
      check("t6_rst_valid", 32'(out_valid), 32'd0);
      check("t6_rst_c", 32'(out_c), 32'd0);
      check("t6_rst_ovf", 32'(out_ovf), 32'd0);
      check("t6_rst_sticky", 32'(sticky_ovf), 32'd0);
      check("t6_rst_alu", {alu_a, alu_b}, 32'd0);
      check("t6_rst_func", 32'(alu_func), 32'd0);
      sb_q.delete();
      #2;
      reset_n = 1'b1;
      out_ready = 1'b1;
      set_cmd(16'h0100, 16'h0023, FUNC_ADD);
      step();
      idle();
      check("t6_post_wait", 32'(out_valid), 32'd0);
      step();
      check("t6_post_valid", 32'(out_valid), 32'd1);
      check("t6_post_c", 32'(out_c), 32'h0123);
      drain("t6_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_alu_cmd_queue
